// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch stage.
//   addr_t        word address (PC) type at the default width
//   instr_t       instruction word type at the default width
//   fetch_entry_t one buffered fetch result {instr, pc}
//   cnt_w()       bits needed to hold an occupancy count 0..depth
package fetch_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_INSTR_W    = 32;
    localparam int DEF_FIFO_DEPTH = 2;
    localparam logic [DEF_ADDR_W-1:0] RESET_PC_DEF = '0;

    typedef logic [DEF_ADDR_W-1:0]  addr_t;
    typedef logic [DEF_INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory bus plus decode valid/ready handshake.
//   master (fetch unit): drives imem_addr, instr_valid, instr, instr_pc
//                        samples imem_rdata, instr_ready
//   slave  (memory/decode side): the mirror image
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output imem_addr, instr_valid, instr, instr_pc,
        input  imem_rdata, instr_ready
    );

    modport slave (
        input  imem_addr, instr_valid, instr, instr_pc,
        output imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetched {instr, pc} entries.
//   clk, reset      clock, async active-high reset
//   push/push_*     write one entry at the tail
//   pop             drop the head entry (ignored when empty)
//   flush           empty the buffer; takes priority over push/pop
//   head_instr/pc   entry at the head (meaningful only when count != 0)
//   count           number of valid entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [INSTR_W-1:0]        push_instr,
    input  logic [ADDR_W-1:0]         push_pc,
    input  logic                      pop,
    input  logic                      flush,
    output logic [INSTR_W-1:0]        head_instr,
    output logic [ADDR_W-1:0]         head_pc,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop & (cnt_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)   wr_q <= nxt(wr_q);
            if (pop_ok) rd_q <= nxt(rd_q);
            if (push && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed behind count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= '{instr: push_instr, pc: push_pc};
    end

    assign head_instr = mem_q[rd_q].instr;
    assign head_pc    = mem_q[rd_q].pc;
    assign count      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a 1-cycle synchronous-read imem.
// Owns the PC, issues one word address per cycle while buffer space allows,
// captures the returned word one cycle later and hands {instr, pc} to decode.
//   clk, reset          clock, async active-high reset
//   fetch_en            1 = issue fetches, 0 = freeze issue (buffer still drains)
//   redirect/_pc        1-cycle pulse: flush everything, refetch from redirect_pc
//   bus (fetch_if.master) imem_addr/imem_rdata, instr_valid/instr/instr_pc/instr_ready
//   perf_fetched/_stall (only with FETCH_PERF_CNT_EN) saturating pop / stall counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                INSTR_W    = DEF_INSTR_W,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_if.master           bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);
    localparam int CW = cnt_w(FIFO_DEPTH);

    logic [ADDR_W-1:0]  a_q, rd_pc_q;
    logic               inflight_q;
    logic [CW-1:0]      count;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               instr_valid, pop, push, issue;
    logic [CW:0]        occ;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & bus.instr_ready;
    assign push        = inflight_q & ~redirect;

    // Space check counts the word leaving this cycle as freed; without it a
    // 2-deep buffer would only sustain one word every other cycle.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign issue = fetch_en & ~redirect & (occ < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= RESET_PC;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
        end else if (redirect) begin
            // in-flight word is dropped; memory re-reads from the new PC
            a_q        <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                rd_pc_q <= a_q;
                a_q     <= a_q + 1'b1;   // wraps silently at the top
            end
        end
    end

    fetch_fifo #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_instr (bus.imem_rdata),
        .push_pc    (rd_pc_q),
        .pop        (pop & ~redirect),
        .flush      (redirect),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (count)
    );

    assign bus.imem_addr   = a_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = instr_valid ? head_instr : '0;
    assign bus.instr_pc    = instr_valid ? head_pc    : '0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop && perf_fetched != '1)
                perf_fetched <= perf_fetched + 1'b1;
            if (instr_valid && !bus.instr_ready && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a scoreboard of expected
// {instr, pc} words, a 1-cycle sync-read memory model (mem[k] = k+1) and a
// second instance whose reset PC is the top address.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;
    localparam logic [AW-1:0] MAXPC = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset, fetch_en, redirect, ready;
    logic [AW-1:0] redirect_pc;
    logic          w_fetch_en = 1'b1;
    logic          w_redirect = 1'b0;
    logic [AW-1:0] w_redirect_pc = '0;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int stall_cnt = 0;

    fetch_entry_t exp_q[$];

    fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
    fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) wbus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(DEPTH), .RESET_PC(MAXPC)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (w_fetch_en),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .bus         (wbus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(w_perf_fetched),
        .perf_stall  (w_perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous-read memory: word at address k is k+1
    always @(posedge clk) begin
        bus.imem_rdata  <= bus.imem_addr + 1;
        wbus.imem_rdata <= wbus.imem_addr + 1;
    end
    assign bus.instr_ready  = ready;
    assign wbus.instr_ready = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [AW-1:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + AW'(i);
            e.instr = e.pc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted word must be the next expected one.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (reset) begin
            hs_cnt    = 0;
            stall_cnt = 0;
        end else begin
            if (bus.instr_valid && ready) hs_cnt++;
            if (bus.instr_valid && !ready) stall_cnt++;
            if (!redirect && bus.instr_valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", {32'h0, bus.instr_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", 64'(bus.instr), 64'(e.instr));
                    chk("sb_pc", 64'(bus.instr_pc), 64'(e.pc));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        #12;
        // reset state
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instr", 64'(bus.instr), 64'd0);
        chk("rst_pc", 64'(bus.instr_pc), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_wrap_addr", 64'(wbus.imem_addr), 64'(MAXPC));
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", 64'(perf_fetched), 64'd0);
        chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif

        // 1: stream from PC 0, first word after two edges
        fetch_en = 1'b1; ready = 1'b1;
        fill(0, 12);
        reset = 1'b0;
        step();
        chk("s1_latency_valid", 64'(bus.instr_valid), 64'd0);
        step();
        chk("s1_w0_instr", 64'(bus.instr), 64'h1);
        chk("s1_w0_pc", 64'(bus.instr_pc), 64'h0);
        chk("s6_wrap_pc0", 64'(wbus.instr_pc), 64'(MAXPC));
        chk("s6_wrap_instr0", 64'(wbus.instr), 64'h0);
        step();
        chk("s1_w1_instr", 64'(bus.instr), 64'h2);
        chk("s1_w1_pc", 64'(bus.instr_pc), 64'h1);
        chk("s6_wrap_pc1", 64'(wbus.instr_pc), 64'h0);
        chk("s6_wrap_instr1", 64'(wbus.instr), 64'h1);

        // 2: decode stalls for 5 cycles with pc 1 at the head
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) begin
                chk("s6_wrap_pc2", 64'(wbus.instr_pc), 64'h1);
                chk("s6_wrap_instr2", 64'(wbus.instr), 64'h2);
            end
            chk("s2_hold_valid", 64'(bus.instr_valid), 64'd1);
            chk("s2_hold_instr", 64'(bus.instr), 64'h2);
            chk("s2_hold_pc", 64'(bus.instr_pc), 64'h1);
            chk("s2_addr_frozen", 64'(bus.imem_addr), 64'h3);
        end
        ready = 1'b1;
        step();
        chk("s2_rel_instr", 64'(bus.instr), 64'h3);
        chk("s2_rel_pc", 64'(bus.instr_pc), 64'h2);
        step();
        chk("s2_rel2_instr", 64'(bus.instr), 64'h4);
        chk("s2_rel2_pc", 64'(bus.instr_pc), 64'h3);
`ifdef FETCH_PERF_CNT_EN
        chk("s2_perf_stall", 64'(perf_stall), 64'd5);
`endif

        // 3: redirect to 8 while the buffer is full
        ready = 1'b0;
        repeat (3) step();
        chk("s3_full_valid", 64'(bus.instr_valid), 64'd1);
        redirect = 1'b1; redirect_pc = 32'd8;
        exp_q.delete();
        fill(8, 4);
        step();
        redirect = 1'b0;
        chk("s3_flush_valid", 64'(bus.instr_valid), 64'd0);
        chk("s3_addr", 64'(bus.imem_addr), 64'd8);
        step();
        chk("s3_gap_valid", 64'(bus.instr_valid), 64'd0);
        ready = 1'b1;
        step();
        chk("s3_w8_instr", 64'(bus.instr), 64'h9);
        chk("s3_w8_pc", 64'(bus.instr_pc), 64'h8);
        step();
        chk("s3_w9_instr", 64'(bus.instr), 64'ha);
        chk("s3_w9_pc", 64'(bus.instr_pc), 64'h9);

        // 4: redirect coinciding with a pop and a push while streaming
        repeat (2) step();
        chk("s4_streaming", 64'(bus.instr_valid), 64'd1);
        redirect = 1'b1; redirect_pc = 32'd3;
        exp_q.delete();
        fill(3, 4);
        step();
        redirect = 1'b0;
        chk("s4_flush_empty", 64'(bus.instr_valid), 64'd0);
        step();
        chk("s4_gap_valid", 64'(bus.instr_valid), 64'd0);
        step();
        chk("s4_w3_instr", 64'(bus.instr), 64'h4);
        chk("s4_w3_pc", 64'(bus.instr_pc), 64'h3);
        step();
        chk("s4_w4_instr", 64'(bus.instr), 64'h5);

        // 5: asynchronous reset between edges, mid-stream
        #3;
        reset = 1'b1;
        #1;
        chk("s5_async_valid", 64'(bus.instr_valid), 64'd0);
        chk("s5_async_addr", 64'(bus.imem_addr), 64'd0);
        chk("s5_async_instr", 64'(bus.instr), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("s5_perf_fetched_rst", 64'(perf_fetched), 64'd0);
`endif
        exp_q.delete();
        fill(0, 6);
        @(posedge clk);
        #3;
        reset = 1'b0;
        step();
        chk("s5_latency_valid", 64'(bus.instr_valid), 64'd0);
        step();
        chk("s5_w0_instr", 64'(bus.instr), 64'h1);
        chk("s5_w0_pc", 64'(bus.instr_pc), 64'h0);
        step();
        chk("s5_w1_instr", 64'(bus.instr), 64'h2);
        repeat (2) step();

`ifdef FETCH_PERF_CNT_EN
        chk("end_perf_fetched", 64'(perf_fetched), 64'(hs_cnt));
        chk("end_perf_stall", 64'(perf_stall), 64'(stall_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
